sound_ram_dp: RTL and testbench

Parametrised dual-port synchronous RAM for the sound subsystem. It generalises the sound CPU's 2K×8 work RAM to configurable width and depth and adds a second independent read/write port for host/debug access or a sound-chip DMA. It also adds a selectable read-during-write mode and a hardware fill engine. The fill engine re-initialises the whole array after reset or on request, so power-up contents no longer depend on initial blocks.

---
 rtl/sound_ram_dp.sv | 174 +++++++++++++++++
 tb/tb_sound_ram_dp.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_ram_dp.sv
// sound_ram_dp: parametrised dual-port synchronous RAM for the sound subsystem.
//
// Two independent read/write ports share one array. Port A normally serves the
// sound CPU, port B a host/debug agent or sound-chip DMA. A fill engine walks
// the whole array writing FILL_VALUE after reset and on every clear_req pulse
// seen while idle, so contents never depend on power-up state.
//
// Parameters:
//   ADDR_W        address width, depth = 2**ADDR_W
//   DATA_W        word width
//   FILL_VALUE    word written to every location by the fill engine
//   WRITE_THROUGH same-port read-during-write: 0 = old data, 1 = new data
//
// Ports:
//   clk        clock, everything updates on its rising edge
//   reset_n    synchronous active-low reset, starts a fill pass
//   a_addr     port A address
//   a_we       port A write enable
//   a_din      port A write data
//   a_q        port A registered read data
//   b_addr     port B address
//   b_we       port B write enable
//   b_din      port B write data
//   b_q        port B registered read data
//   clear_req  one-cycle pulse, starts a fill pass when idle
//   busy       high while a fill pass is running; port writes are ignored
module sound_ram_dp #(
  parameter int unsigned          ADDR_W        = 11,
  parameter int unsigned          DATA_W        = 8,
  parameter logic [DATA_W-1:0]    FILL_VALUE    = '0,
  parameter bit                   WRITE_THROUGH = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_q,
  input  logic              clear_req,
  output logic              busy
);

  localparam int unsigned       Depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic {
    StIdle,
    StFill
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  logic [DATA_W-1:0] mem [Depth];

  logic              fill_active;
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;

  // Fill engine: the request edge itself performs no fill write, the pass
  // starts on the following edge and ends after writing the last address.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StFill;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StFill: begin
        if (ptr_q == LastAddr) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = StFill;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StFill;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign fill_active = (state_q == StFill);

  // The fill engine borrows the port A write path. On a same-address double
  // write port A wins, so port B's write is suppressed.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = a_addr;
    wa_data = a_din;
    wb_en   = 1'b0;
    if (fill_active) begin
      wa_en   = 1'b1;
      wa_addr = ptr_q;
      wa_data = FILL_VALUE;
    end else begin
      wa_en = a_we;
      wb_en = b_we && !(a_we && (a_addr == b_addr));
    end
  end

  // No writes on a reset edge, so reset_n also acts as the array write gate.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (wa_en) begin
        mem[wa_addr] <= wa_data;
      end
      if (wb_en) begin
        mem[b_addr] <= b_din;
      end
    end
  end

  // Reads sample the array before this edge's writes land, so a reader on the
  // other port always sees old data; write-through only bypasses own-port data.
  always_comb begin
    rd_a_d = mem[a_addr];
    rd_b_d = mem[b_addr];
    if (fill_active) begin
      rd_a_d = FILL_VALUE;
      rd_b_d = FILL_VALUE;
    end else begin
      if (WRITE_THROUGH && a_we) begin
        rd_a_d = a_din;
      end
      if (WRITE_THROUGH && b_we) begin
        rd_b_d = b_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign a_q  = rd_a_q;
  assign b_q  = rd_b_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sound_ram_dp.sv
// Bench for sound_ram_dp: a default build (2K x 8, read-first, fill 0x00) and a
// small build (16 x 16, write-through, fill 0x00AA) share one clock.
module tb_sound_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build.
  logic        r0_n;
  logic [10:0] a0_addr, b0_addr;
  logic        a0_we, b0_we, clr0;
  logic [7:0]  a0_din, b0_din;
  logic [7:0]  a0_q, b0_q;
  logic        busy0;

  // Small write-through build.
  logic        r1_n;
  logic [3:0]  a1_addr, b1_addr;
  logic        a1_we, b1_we, clr1;
  logic [15:0] a1_din, b1_din;
  logic [15:0] a1_q, b1_q;
  logic        busy1;

  sound_ram_dp dut0 (
    .clk       (clk),
    .reset_n   (r0_n),
    .a_addr    (a0_addr),
    .a_we      (a0_we),
    .a_din     (a0_din),
    .a_q       (a0_q),
    .b_addr    (b0_addr),
    .b_we      (b0_we),
    .b_din     (b0_din),
    .b_q       (b0_q),
    .clear_req (clr0),
    .busy      (busy0)
  );

  sound_ram_dp #(
    .ADDR_W        (4),
    .DATA_W        (16),
    .FILL_VALUE    (16'h00AA),
    .WRITE_THROUGH (1'b1)
  ) dut1 (
    .clk       (clk),
    .reset_n   (r1_n),
    .a_addr    (a1_addr),
    .a_we      (a1_we),
    .a_din     (a1_din),
    .a_q       (a1_q),
    .b_addr    (b1_addr),
    .b_we      (b1_we),
    .b_din     (b1_din),
    .b_q       (b1_q),
    .clear_req (clr1),
    .busy      (busy1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    string       name;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [10:0] aa;
    logic        awe;
    logic [7:0]  ad;
    logic [10:0] ba;
    logic        bwe;
    logic [7:0]  bd;
    logic [7:0]  ea;
    logic [7:0]  eb;
  } vec_t;

  vec_t tv[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input logic [15:0] aq, input logic [15:0] bq);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue want one entry");
    end else begin
      total--;
      e = sb.pop_front();
      check({e.name, " a_q"}, aq, e.a);
      check({e.name, " b_q"}, bq, e.b);
    end
  endtask

  task automatic step0(input string name, input logic [10:0] aa, input logic awe,
                       input logic [7:0] ad, input logic [10:0] ba, input logic bwe,
                       input logic [7:0] bd, input logic [7:0] ea, input logic [7:0] eb);
    a0_addr = aa; a0_we = awe; a0_din = ad;
    b0_addr = ba; b0_we = bwe; b0_din = bd;
    sb.push_back('{a: {8'h00, ea}, b: {8'h00, eb}, name: name});
    tick();
    sb_pop({8'h00, a0_q}, {8'h00, b0_q});
    a0_we = 1'b0; b0_we = 1'b0;
  endtask

  task automatic step1(input string name, input logic [3:0] aa, input logic awe,
                       input logic [15:0] ad, input logic [3:0] ba, input logic bwe,
                       input logic [15:0] bd, input logic [15:0] ea, input logic [15:0] eb);
    a1_addr = aa; a1_we = awe; a1_din = ad;
    b1_addr = ba; b1_we = bwe; b1_din = bd;
    sb.push_back('{a: ea, b: eb, name: name});
    tick();
    sb_pop(a1_q, b1_q);
    a1_we = 1'b0; b1_we = 1'b0;
  endtask

  // Runs fill edges until busy drops (bounded); returns the number of edges.
  // Port writes are attempted throughout when wr is set and must be ignored.
  task automatic fill_run0(input string name, input bit wr, input int mid_clr, output int n);
    n = 0;
    do begin
      clr0 = (n == mid_clr);
      a0_we = wr; b0_we = wr;
      a0_addr = 11'($urandom); b0_addr = 11'($urandom);
      a0_din = 8'h55; b0_din = 8'h66;
      tick();
      n++;
      check({name, " a_q during fill"}, {8'h00, a0_q}, 16'h0000);
      check({name, " b_q during fill"}, {8'h00, b0_q}, 16'h0000);
    end while (busy0 && n < 5000);
    clr0 = 1'b0; a0_we = 1'b0; b0_we = 1'b0;
  endtask

  task automatic fill_run1(input string name, input bit wr, input int mid_clr, output int n);
    n = 0;
    do begin
      clr1 = (n == mid_clr);
      a1_we = wr; b1_we = wr;
      a1_addr = 4'($urandom); b1_addr = 4'($urandom);
      a1_din = 16'h5555; b1_din = 16'h6666;
      tick();
      n++;
      check({name, " a_q during fill"}, a1_q, 16'h00AA);
      check({name, " b_q during fill"}, b1_q, 16'h00AA);
    end while (busy1 && n < 200);
    clr1 = 1'b0; a1_we = 1'b0; b1_we = 1'b0;
  endtask

  task automatic sweep0(input string name, input logic [7:0] v);
    for (int i = 0; i < 2048; i++) begin
      step0(name, 11'(i), 1'b0, 8'h00, 11'(2047 - i), 1'b0, 8'h00, v, v);
    end
  endtask

  task automatic sweep1(input string name, input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      step1(name, 4'(i), 1'b0, 16'h0, 4'(15 - i), 1'b0, 16'h0, v, v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Hand-derived vectors for the default build, memory all zero beforehand.
    tv[0]  = '{11'h123, 1'b1, 8'h5A, 11'h123, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[1]  = '{11'h123, 1'b0, 8'h00, 11'h123, 1'b0, 8'h00, 8'h5A, 8'h5A};
    tv[2]  = '{11'h010, 1'b1, 8'h11, 11'h010, 1'b1, 8'h22, 8'h00, 8'h00};
    tv[3]  = '{11'h010, 1'b0, 8'h00, 11'h010, 1'b0, 8'h00, 8'h11, 8'h11};
    tv[4]  = '{11'h010, 1'b1, 8'h33, 11'h010, 1'b0, 8'h00, 8'h11, 8'h11};
    tv[5]  = '{11'h010, 1'b0, 8'h00, 11'h010, 1'b0, 8'h00, 8'h33, 8'h33};
    tv[6]  = '{11'h7FF, 1'b0, 8'h00, 11'h7FF, 1'b1, 8'h77, 8'h00, 8'h00};
    tv[7]  = '{11'h7FF, 1'b0, 8'h00, 11'h000, 1'b0, 8'h00, 8'h77, 8'h00};
    tv[8]  = '{11'h000, 1'b1, 8'h9C, 11'h001, 1'b1, 8'hC3, 8'h00, 8'h00};
    tv[9]  = '{11'h001, 1'b0, 8'h00, 11'h000, 1'b0, 8'h00, 8'hC3, 8'h9C};
    tv[10] = '{11'h123, 1'b0, 8'h00, 11'h123, 1'b1, 8'h44, 8'h5A, 8'h5A};
    tv[11] = '{11'h123, 1'b0, 8'h00, 11'h010, 1'b0, 8'h00, 8'h44, 8'h33};

    r0_n = 1'b0; a0_addr = '0; a0_we = 1'b0; a0_din = '0;
    b0_addr = '0; b0_we = 1'b0; b0_din = '0; clr0 = 1'b0;
    r1_n = 1'b0; a1_addr = '0; a1_we = 1'b0; a1_din = '0;
    b1_addr = '0; b1_we = 1'b0; b1_din = '0; clr1 = 1'b0;

    // Reset held three cycles on both builds.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset busy0", {15'd0, busy0}, 16'd1);
      check("reset a0_q", {8'h00, a0_q}, 16'h0000);
      check("reset b0_q", {8'h00, b0_q}, 16'h0000);
      check("reset busy1", {15'd0, busy1}, 16'd1);
      check("reset a1_q", a1_q, 16'h0000);
    end

    // Small build: reset fill lasts 16 edges.
    r1_n = 1'b1;
    fill_run1("wt reset fill", 1'b1, -1, n);
    check("wt reset fill edges", 16'(n), 16'd16);
    sweep1("wt after reset fill", 16'h00AA);
    step1("wt write a", 4'h3, 1'b1, 16'hBEEF, 4'h3, 1'b0, 16'h0, 16'hBEEF, 16'h00AA);
    step1("wt write b", 4'h3, 1'b0, 16'h0, 4'h5, 1'b1, 16'h1234, 16'hBEEF, 16'h1234);
    step1("wt read back", 4'h5, 1'b0, 16'h0, 4'h3, 1'b0, 16'h0, 16'h1234, 16'hBEEF);
    for (int i = 0; i < 16; i++) begin
      step1("wt fill ff", 4'(i), 1'b1, 16'hFFFF, 4'(i), 1'b0, 16'h0, 16'hFFFF,
            (i == 3) ? 16'hBEEF : (i == 5) ? 16'h1234 : 16'h00AA);
    end
    sweep1("wt ff readback", 16'hFFFF);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check("wt clear request busy", {15'd0, busy1}, 16'd1);
    fill_run1("wt clear fill", 1'b1, 5, n);
    check("wt clear busy cycles", 16'(n + 1), 16'd17);
    sweep1("wt after clear", 16'h00AA);

    // Default build: reset fill lasts 2048 edges, q stays zero.
    r0_n = 1'b1;
    fill_run0("reset fill", 1'b0, -1, n);
    check("reset fill edges", 16'(n), 16'd2048);
    check("busy low after fill", {15'd0, busy0}, 16'd0);
    sweep0("after reset fill", 8'h00);

    for (int i = 0; i < 12; i++) begin
      step0($sformatf("vec%0d", i), tv[i].aa, tv[i].awe, tv[i].ad,
            tv[i].ba, tv[i].bwe, tv[i].bd, tv[i].ea, tv[i].eb);
    end

    // Fill with 0xFF, then clear with writes attempted and a second request mid-pass.
    for (int i = 0; i < 2048; i++) begin
      a0_addr = 11'(i); a0_we = 1'b1; a0_din = 8'hFF;
      tick();
    end
    a0_we = 1'b0;
    sweep0("ff readback", 8'hFF);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("clear request busy", {15'd0, busy0}, 16'd1);
    fill_run0("clear fill", 1'b1, 700, n);
    check("clear busy cycles", 16'(n + 1), 16'd2049);
    sweep0("after clear", 8'h00);

    // Reset 1000 edges into a pass restarts it from address 0.
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!busy0) begin
        check("busy held before abort", {15'd0, busy0}, 16'd1);
        break;
      end
    end
    r0_n = 1'b0;
    tick();
    check("abort reset busy", {15'd0, busy0}, 16'd1);
    r0_n = 1'b1;
    fill_run0("abort refill", 1'b0, -1, n);
    check("abort refill edges", 16'(n), 16'd2048);
    step0("post abort read", 11'h3FF, 1'b0, 8'h00, 11'h000, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
